ex_stage: RTL and testbench



---
 rtl/ex_stage_pkg.sv | 95 +++++++++
 rtl/div_iter.sv | 81 ++++++++
 rtl/ex_stage.sv | 156 +++++++++++++++
 tb/tb_ex_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared execute-stage definitions: bus widths, stall encoding, ALU/memory op codes and bus layouts.
// The pipeline-register layouts below are the contract with the ID and MEM stages.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 143;
  localparam int EX_TO_MEM_WD = 80;
  localparam int EX_TO_ID_WD  = 38;
  localparam int STALLBUS_W   = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;

  // ALU_ADD must stay 0 so that an all-zero bubble computes 0+0 and drives nothing
  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLT   = 5'd2,
    ALU_SLTU  = 5'd3,
    ALU_AND   = 5'd4,
    ALU_OR    = 5'd5,
    ALU_XOR   = 5'd6,
    ALU_NOR   = 5'd7,
    ALU_SLL   = 5'd8,
    ALU_SRL   = 5'd9,
    ALU_SRA   = 5'd10,
    ALU_LUI   = 5'd11,
    ALU_MULT  = 5'd12,
    ALU_MULTU = 5'd13,
    ALU_DIV   = 5'd14,
    ALU_DIVU  = 5'd15,
    ALU_MFHI  = 5'd16,
    ALU_MFLO  = 5'd17,
    ALU_MTHI  = 5'd18,
    ALU_MTLO  = 5'd19
  } alu_op_e;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LW   = 4'd1,
    MEM_LB   = 4'd2,
    MEM_LBU  = 4'd3,
    MEM_LH   = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SW   = 4'd6,
    MEM_SB   = 4'd7,
    MEM_SH   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [3:0]  mem_op;
    logic [31:0] st_data;
  } id_to_ex_t;

  typedef struct packed {
    logic [3:0]  readen;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  // Load-type code handed to MEM so it can extract and extend the returned word
  function automatic logic [3:0] readen_of(input logic [3:0] mem_op);
    logic [3:0] res;
    res = 4'b0000;
    case (mem_op)
      MEM_LW:  res = 4'b1111;
      MEM_LB:  res = 4'b0001;
      MEM_LBU: res = 4'b0010;
      MEM_LH:  res = 4'b0011;
      MEM_LHU: res = 4'b0100;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/div_iter.sv
// 32-step restoring divider: 1 cycle to latch operands, 32 BUSY cycles, then holds the result in DONE.
// Result is held until ack; a new start is only accepted from IDLE.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  div_state_e  state_r, state_n;
  logic [4:0]  cnt_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic        neg_q_r;
  logic        neg_r_r;

  logic [31:0] a_abs, b_abs;
  logic [32:0] trial;
  logic [31:0] diff;
  logic        ge;

  assign a_abs = (is_signed && a[31]) ? -a : a;
  assign b_abs = (is_signed && b[31]) ? -b : b;

  // Remainder stays below the divisor, so the true difference always fits in 32 bits
  assign trial = {rem_r, quo_r[31]};
  assign ge    = (trial >= {1'b0, dvs_r});
  assign diff  = trial[31:0] - dvs_r;

  always_comb begin
    state_n = state_r;
    case (state_r)
      DIV_IDLE: if (start)            state_n = DIV_BUSY;
      DIV_BUSY: if (cnt_r == 5'd31)   state_n = DIV_DONE;
      DIV_DONE: if (ack)              state_n = DIV_IDLE;
      default:                        state_n = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DIV_IDLE;
      cnt_r   <= '0;
      rem_r   <= '0;
      quo_r   <= '0;
      dvs_r   <= '0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      state_r <= state_n;
      if (state_r == DIV_IDLE && start) begin
        cnt_r   <= '0;
        rem_r   <= '0;
        quo_r   <= a_abs;
        dvs_r   <= b_abs;
        neg_q_r <= is_signed && (a[31] ^ b[31]);
        neg_r_r <= is_signed && a[31];
      end else if (state_r == DIV_BUSY) begin
        cnt_r <= cnt_r + 5'd1;
        rem_r <= ge ? diff : trial[31:0];
        quo_r <= {quo_r[30:0], ge};
      end
    end
  end

  assign busy = (state_r == DIV_BUSY);
  assign done = (state_r == DIV_DONE);
  assign quot = neg_q_r ? -quo_r : quo_r;
  assign rem  = neg_r_r ? -rem_r : rem_r;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, ALU, HI/LO with multiply/divide, load/store address and SRAM request.
// Results are combinational from the ID/EX register; a divide raises stallreq_for_ex until its result is ready.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALLBUS_W-1:0]   stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id,
  output logic                    ex_is_load,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  id_to_ex_t   r;
  ex_to_mem_t  m;
  logic        advance;
  logic        unused_stall;

  logic [31:0] hi_r, lo_r;
  logic [31:0] sum;
  logic [31:0] alu_res;
  logic [63:0] prod_s, prod_u;
  logic        is_div;
  logic        is_load;
  logic [3:0]  wen;
  logic [31:0] wdata;

  logic        div_busy, div_done;
  logic [31:0] div_quot, div_rem;

  assign unused_stall = ^{stall[5:4], stall[1:0]};
  assign advance      = (stall[STALL_EX_MEM] == NO_STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
    end else if (stall[STALL_ID_EX] == STOP && stall[STALL_EX_MEM] == NO_STOP) begin
      r <= '0;
    end else if (stall[STALL_ID_EX] == NO_STOP) begin
      r <= id_to_ex_t'(id_to_ex_bus);
    end
  end

  assign sum    = r.src1 + r.src2;
  assign prod_s = $signed({{32{r.src1[31]}}, r.src1}) * $signed({{32{r.src2[31]}}, r.src2});
  assign prod_u = {32'd0, r.src1} * {32'd0, r.src2};

  always_comb begin
    alu_res = '0;
    case (r.alu_op)
      ALU_ADD:  alu_res = sum;
      ALU_SUB:  alu_res = r.src1 - r.src2;
      ALU_SLT:  alu_res = {31'd0, ($signed(r.src1) < $signed(r.src2))};
      ALU_SLTU: alu_res = {31'd0, (r.src1 < r.src2)};
      ALU_AND:  alu_res = r.src1 & r.src2;
      ALU_OR:   alu_res = r.src1 | r.src2;
      ALU_XOR:  alu_res = r.src1 ^ r.src2;
      ALU_NOR:  alu_res = ~(r.src1 | r.src2);
      ALU_SLL:  alu_res = r.src2 << r.src1[4:0];
      ALU_SRL:  alu_res = r.src2 >> r.src1[4:0];
      ALU_SRA:  alu_res = $signed(r.src2) >>> r.src1[4:0];
      ALU_LUI:  alu_res = {r.src2[15:0], 16'd0};
      ALU_MFHI: alu_res = hi_r;
      ALU_MFLO: alu_res = lo_r;
      default:  alu_res = '0;
    endcase
  end

  assign is_div = (r.alu_op == ALU_DIV) || (r.alu_op == ALU_DIVU);

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .is_signed (r.alu_op == ALU_DIV),
    .a         (r.src1),
    .b         (r.src2),
    .ack       (advance),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  // The cycle a divide first appears the FSM is still IDLE, so it must already request the stall
  assign stallreq_for_ex = (is_div && !div_busy && !div_done) || div_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (advance) begin
      case (r.alu_op)
        ALU_MULT:  {hi_r, lo_r} <= prod_s;
        ALU_MULTU: {hi_r, lo_r} <= prod_u;
        ALU_MTHI:  hi_r <= r.src1;
        ALU_MTLO:  lo_r <= r.src1;
        ALU_DIV, ALU_DIVU: begin
          if (div_done) begin
            hi_r <= div_rem;
            lo_r <= div_quot;
          end
        end
        default: ;
      endcase
    end
  end

  assign is_load = (r.mem_op >= MEM_LW) && (r.mem_op <= MEM_LHU);

  // Sub-word stores replicate the data across lanes; the byte enables pick the lane
  always_comb begin
    wen   = 4'b0000;
    wdata = '0;
    case (r.mem_op)
      MEM_SW: begin
        wen   = 4'b1111;
        wdata = r.st_data;
      end
      MEM_SB: begin
        wen   = 4'b0001 << sum[1:0];
        wdata = {4{r.st_data[7:0]}};
      end
      MEM_SH: begin
        wen   = 4'b0011 << sum[1:0];
        wdata = {2{r.st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign data_sram_en    = (r.mem_op != MEM_NONE) && (r.mem_op <= MEM_SH);
  assign data_sram_wen   = wen;
  assign data_sram_addr  = sum;
  assign data_sram_wdata = wdata;

  assign m.readen     = readen_of(r.mem_op);
  assign m.pc         = r.pc;
  assign m.ram_en     = data_sram_en;
  assign m.ram_wen    = wen;
  assign m.sel_rf_res = is_load;
  assign m.rf_we      = r.rf_we;
  assign m.rf_waddr   = r.rf_waddr;
  assign m.ex_result  = alu_res;

  assign ex_to_mem_bus = m;
  assign ex_to_id      = {r.rf_we, r.rf_waddr, alu_res};
  assign ex_is_load    = is_load;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, load/store alignment, bubbles, HI/LO via mult/div, reset mid-divide.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [142:0] id_to_ex_bus;
  logic [79:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id;
  logic         ex_is_load;
  logic         stallreq_for_ex;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int n_chk  = 0;
  int n_fail = 0;
  int ncyc;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_id        (ex_to_id),
    .ex_is_load      (ex_is_load),
    .stallreq_for_ex (stallreq_for_ex),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [142:0] ins(input logic [31:0] pc, input logic [4:0] op,
                                       input logic [31:0] s1, input logic [31:0] s2,
                                       input logic we, input logic [4:0] wa,
                                       input logic [3:0] mop, input logic [31:0] st);
    return {pc, op, s1, s2, we, wa, mop, st};
  endfunction

  function automatic logic [79:0] mem(input logic [3:0] rd, input logic [31:0] pc,
                                      input logic en, input logic [3:0] wen, input logic sel,
                                      input logic we, input logic [4:0] wa, input logic [31:0] res);
    return {rd, pc, en, wen, sel, we, wa, res};
  endfunction

  task automatic issue(input logic [142:0] i);
    id_to_ex_bus = i;
    stall        = 6'b000000;
    step();
  endtask

  // Holds EX and EX/MEM while the divider asks for it; counts the stalled cycles
  task automatic run_div(output int n);
    n = 0;
    while (stallreq_for_ex && n < 100) begin
      stall = 6'b001111;
      step();
      n++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    stall        = 6'b000000;
    id_to_ex_bus = '0;
    step();
    step();
    check("rst_bus",   ex_to_mem_bus, 80'(0));
    check("rst_fwd",   80'(ex_to_id), 80'(0));
    check("rst_stall", 80'(stallreq_for_ex), 80'(0));
    check("rst_en",    80'(data_sram_en), 80'(0));
    rst = 1'b0;

    issue(ins(32'h100, ALU_ADD, 32'd7, 32'hFFFF_FFFD, 1'b1, 5'd5, MEM_NONE, 32'd0));
    check("add_bus", ex_to_mem_bus, mem(4'b0, 32'h100, 1'b0, 4'b0, 1'b0, 1'b1, 5'd5, 32'd4));
    check("add_fwd", 80'(ex_to_id), 80'({1'b1, 5'd5, 32'd4}));

    issue(ins(32'h104, ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 1'b0, 5'd3, MEM_NONE, 32'd0));
    check("sltu_fwd", 80'(ex_to_id), 80'({1'b0, 5'd3, 32'd1}));

    issue(ins(32'h108, ALU_ADD, 32'h1000, 32'd3, 1'b0, 5'd0, MEM_SB, 32'h0000_00AB));
    check("sb_wen",   80'(data_sram_wen), 80'(4'b1000));
    check("sb_wdata", 80'(data_sram_wdata), 80'(32'hABAB_ABAB));
    check("sb_addr",  80'(data_sram_addr), 80'(32'h1003));
    check("sb_en",    80'(data_sram_en), 80'(1));
    check("sb_load",  80'(ex_is_load), 80'(0));

    issue(ins(32'h10C, ALU_ADD, 32'h3000, 32'd2, 1'b0, 5'd0, MEM_SH, 32'h5555_1234));
    check("sh_wen",   80'(data_sram_wen), 80'(4'b1100));
    check("sh_wdata", 80'(data_sram_wdata), 80'(32'h1234_1234));

    issue(ins(32'h110, ALU_ADD, 32'h2000, 32'd2, 1'b1, 5'd8, MEM_LH, 32'd0));
    check("lh_bus",  ex_to_mem_bus, mem(4'b0011, 32'h110, 1'b1, 4'b0, 1'b1, 1'b1, 5'd8, 32'h2002));
    check("lh_en",   80'(data_sram_en), 80'(1));
    check("lh_load", 80'(ex_is_load), 80'(1));

    // Bubble: ID/EX stopped while EX/MEM moves on
    id_to_ex_bus = ins(32'h114, ALU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 5'd0, MEM_NONE, 32'd0);
    stall        = 6'b000100;
    step();
    check("bub_bus",  ex_to_mem_bus, 80'(0));
    check("bub_en",   80'(data_sram_en), 80'(0));
    check("bub_fwd",  80'(ex_to_id), 80'(0));
    check("bub_load", 80'(ex_is_load), 80'(0));

    issue(ins(32'h114, ALU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 5'd0, MEM_NONE, 32'd0));
    issue(ins(32'h118, ALU_MFHI, 32'd0, 32'd0, 1'b1, 5'd2, MEM_NONE, 32'd0));
    check("mult_hi", 80'(ex_to_mem_bus[31:0]), 80'(32'hFFFF_FFFF));
    issue(ins(32'h11C, ALU_MFLO, 32'd0, 32'd0, 1'b1, 5'd2, MEM_NONE, 32'd0));
    check("mult_lo", 80'(ex_to_mem_bus[31:0]), 80'(32'hFFFF_FFFA));

    issue(ins(32'h120, ALU_MTLO, 32'h0000_CAFE, 32'd0, 1'b0, 5'd0, MEM_NONE, 32'd0));
    issue(ins(32'h124, ALU_MFLO, 32'd0, 32'd0, 1'b1, 5'd2, MEM_NONE, 32'd0));
    check("mtlo_lo", 80'(ex_to_mem_bus[31:0]), 80'(32'h0000_CAFE));

    // DIV -7/2 with the result held in DONE for a few extra cycles
    issue(ins(32'h128, ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd0, MEM_NONE, 32'd0));
    run_div(ncyc);
    check("div_cycles", 80'(ncyc), 80'(33));
    for (int k = 0; k < 3; k++) begin
      step();
      check("div_hold_stall", 80'(stallreq_for_ex), 80'(0));
    end
    issue(ins(32'h12C, ALU_MFLO, 32'd0, 32'd0, 1'b1, 5'd2, MEM_NONE, 32'd0));
    check("div_lo", 80'(ex_to_mem_bus[31:0]), 80'(32'hFFFF_FFFD));
    issue(ins(32'h130, ALU_MFHI, 32'd0, 32'd0, 1'b1, 5'd2, MEM_NONE, 32'd0));
    check("div_hi", 80'(ex_to_mem_bus[31:0]), 80'(32'hFFFF_FFFF));

    issue(ins(32'h134, ALU_DIVU, 32'd5, 32'd0, 1'b0, 5'd0, MEM_NONE, 32'd0));
    run_div(ncyc);
    check("divz_cycles", 80'(ncyc), 80'(33));
    issue(ins(32'h138, ALU_MFLO, 32'd0, 32'd0, 1'b1, 5'd2, MEM_NONE, 32'd0));
    check("divz_lo", 80'(ex_to_mem_bus[31:0]), 80'(32'hFFFF_FFFF));
    issue(ins(32'h13C, ALU_MFHI, 32'd0, 32'd0, 1'b1, 5'd2, MEM_NONE, 32'd0));
    check("divz_hi", 80'(ex_to_mem_bus[31:0]), 80'(32'd5));

    // Reset in the middle of a divide
    issue(ins(32'h140, ALU_DIVU, 32'd100, 32'd7, 1'b0, 5'd0, MEM_NONE, 32'd0));
    stall = 6'b001111;
    repeat (10) step();
    check("busy_stall", 80'(stallreq_for_ex), 80'(1));
    rst = 1'b1;
    step();
    check("rstb_stall", 80'(stallreq_for_ex), 80'(0));
    check("rstb_bus",   ex_to_mem_bus, 80'(0));
    check("rstb_fwd",   80'(ex_to_id), 80'(0));
    check("rstb_en",    80'(data_sram_en), 80'(0));
    check("rstb_sram",  80'({data_sram_wen, data_sram_addr, data_sram_wdata}), 80'(0));
    rst   = 1'b0;
    stall = 6'b000000;
    issue(ins(32'h144, ALU_MFHI, 32'd0, 32'd0, 1'b1, 5'd2, MEM_NONE, 32'd0));
    check("rstb_hi", 80'(ex_to_mem_bus[31:0]), 80'(0));

    issue(ins(32'h148, ALU_DIVU, 32'd9, 32'd2, 1'b0, 5'd0, MEM_NONE, 32'd0));
    run_div(ncyc);
    check("div2_cycles", 80'(ncyc), 80'(33));
    issue(ins(32'h14C, ALU_MFLO, 32'd0, 32'd0, 1'b1, 5'd2, MEM_NONE, 32'd0));
    check("div2_lo", 80'(ex_to_mem_bus[31:0]), 80'(32'd4));
    issue(ins(32'h150, ALU_MFHI, 32'd0, 32'd0, 1'b1, 5'd2, MEM_NONE, 32'd0));
    check("div2_hi", 80'(ex_to_mem_bus[31:0]), 80'(32'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
